instruction_fetch_unit: RTL and testbench

Single-cycle fetch stage directly upstream of the register-file/decode stage. Holds the PC and a word-addressed instruction store. Presents the current instruction and PC+4 (link address) to decode. Resolves next-PC from branch/jump control plus ALU/register results, and accepts a program-load write port used while the CPU is held in program mode.

---
 rtl/instruction_fetch_unit.sv | 134 +++++++++++++
 tb/tb_instruction_fetch_unit.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// instruction_fetch_unit
//
// Single-cycle fetch stage sitting in front of register-file/decode. Holds the
// PC and a word-addressed instruction store, presents the current instruction
// and PC+4 to decode, and resolves the next PC from jump/branch control.
// While prog_mode is high the CPU is parked at RESET_PC and the store can be
// written through the program-load port.
//
// Ports:
//   clock            system clock, all state changes on the rising edge
//   reset            asynchronous active-low reset
//   stall            hold PC and retired count this cycle
//   prog_mode        program-load mode (fetch suspended, PC parked)
//   prog_we          store write strobe, honoured only in prog_mode
//   prog_addr        store word address for program writes
//   prog_data        instruction word to write
//   Branch/nBranch   beq / bne in flight
//   Jmp/Jal/Jr       j / jal / jr in flight
//   Zero             ALU zero flag
//   Addr_result      branch target from the ALU
//   Read_data_1      rs value (jr target)
//   Instruction      current instruction word (combinational from pc)
//   branch_base_addr pc+4 for the ALU branch adder
//   link_addr        pc+4 as the jal return address
//   pc               current program counter
//   instr_count      retired-fetch counter
// -----------------------------------------------------------------------------
module instruction_fetch_unit #(
    parameter int          ROM_AW   = 14,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              stall,
    input  logic              prog_mode,
    input  logic              prog_we,
    input  logic [ROM_AW-1:0] prog_addr,
    input  logic [31:0]       prog_data,
    input  logic              Branch,
    input  logic              nBranch,
    input  logic              Jmp,
    input  logic              Jal,
    input  logic              Jr,
    input  logic              Zero,
    input  logic [31:0]       Addr_result,
    input  logic [31:0]       Read_data_1,
    output logic [31:0]       Instruction,
    output logic [31:0]       branch_base_addr,
    output logic [31:0]       link_addr,
    output logic [31:0]       pc,
    output logic [31:0]       instr_count
);

    localparam int ROM_DEPTH = 1 << ROM_AW;

    logic [31:0] rom_mem [0:ROM_DEPTH-1];

    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] count_q;
    logic [31:0] count_d;
    logic [31:0] pc_plus4_s;
    logic [31:0] rom_word_s;
    logic [31:0] instr_s;
    logic        in_range_s;
    logic        take_branch_s;

    // Fetch path: store lookup, out-of-range NOP and prog-mode NOP.
    always_comb begin
        pc_plus4_s = pc_q + 32'd4;
        in_range_s = (pc_q[31:ROM_AW+2] == '0);
        rom_word_s = rom_mem[pc_q[ROM_AW+1:2]];
        if (prog_mode) begin
            instr_s = 32'h0000_0000;
        end else if (in_range_s) begin
            instr_s = rom_word_s;
        end else begin
            instr_s = 32'h0000_0000;
        end
    end

    // Next-PC selection: jr > j/jal > taken branch > sequential.
    always_comb begin
        pc_d          = pc_q;
        count_d       = count_q;
        take_branch_s = (Branch & Zero) | (nBranch & ~Zero);
        if (prog_mode) begin
            pc_d    = RESET_PC;
            count_d = 32'd0;
        end else if (stall) begin
            pc_d    = pc_q;
            count_d = count_q;
        end else begin
            count_d = count_q + 32'd1;
            if (Jr) begin
                pc_d = Read_data_1 & 32'hFFFF_FFFC;
            end else if (Jmp | Jal) begin
                // j/jal target stays inside the 256 MB region of the delay slot.
                pc_d = {pc_plus4_s[31:28], instr_s[25:0], 2'b00};
            end else if (take_branch_s) begin
                pc_d = Addr_result & 32'hFFFF_FFFC;
            end else begin
                pc_d = pc_plus4_s;
            end
        end
    end

    // PC and retired-fetch counter registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_q    <= RESET_PC;
            count_q <= 32'd0;
        end else begin
            pc_q    <= pc_d;
            count_q <= count_d;
        end
    end

    // Program-load write port; the store is never cleared and writes made
    // while reset is asserted are discarded.
    always_ff @(posedge clock) begin
        if (reset && prog_mode && prog_we) begin
            rom_mem[prog_addr] <= prog_data;
        end
    end

    assign Instruction      = instr_s;
    assign branch_base_addr = pc_plus4_s;
    assign link_addr        = pc_plus4_s;
    assign pc               = pc_q;
    assign instr_count      = count_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch_unit
//
// Directed bench for instruction_fetch_unit. A behavioural model (program
// image, pc, retired count) follows the architectural rules and is compared
// against the DUT on every falling clock edge; hand-computed literal checks
// pin the key points of the scenario.
// -----------------------------------------------------------------------------
module tb_instruction_fetch_unit;

    logic        clock;
    logic        reset;
    logic        stall;
    logic        prog_mode;
    logic        prog_we;
    logic [13:0] prog_addr;
    logic [31:0] prog_data;
    logic        Branch;
    logic        nBranch;
    logic        Jmp;
    logic        Jal;
    logic        Jr;
    logic        Zero;
    logic [31:0] Addr_result;
    logic [31:0] Read_data_1;
    logic [31:0] Instruction;
    logic [31:0] branch_base_addr;
    logic [31:0] link_addr;
    logic [31:0] pc;
    logic [31:0] instr_count;

    int n_vec = 0;
    int n_err = 0;
    bit cmp_en = 1'b0;

    // Model state
    logic [31:0] m_pc;
    logic [31:0] m_cnt;
    logic [31:0] m_mem [0:63];
    bit          m_val [0:63];
    bit          m_seeded;

    instruction_fetch_unit #(
        .ROM_AW   (14),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .stall            (stall),
        .prog_mode        (prog_mode),
        .prog_we          (prog_we),
        .prog_addr        (prog_addr),
        .prog_data        (prog_data),
        .Branch           (Branch),
        .nBranch          (nBranch),
        .Jmp              (Jmp),
        .Jal              (Jal),
        .Jr               (Jr),
        .Zero             (Zero),
        .Addr_result      (Addr_result),
        .Read_data_1      (Read_data_1),
        .Instruction      (Instruction),
        .branch_base_addr (branch_base_addr),
        .link_addr        (link_addr),
        .pc               (pc),
        .instr_count      (instr_count)
    );

    // Clock generation
    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] prog_word(input int i);
        case (i)
            0:       return 32'h2008_0005;
            1:       return 32'h2009_0003;
            2:       return 32'h1109_0002;
            3:       return 32'h0800_0000;
            8:       return 32'h0C00_0010;
            default: return 32'h2400_0000 + i;
        endcase
    endfunction

    // Whether the model knows what the store holds at the current pc.
    function automatic bit model_instr_known();
        if (prog_mode) return 1'b1;
        if (m_pc[31:16] != 16'h0) return 1'b1;
        return (m_pc[15:8] == 8'h0) && m_val[m_pc[7:2]];
    endfunction

    function automatic logic [31:0] model_instr();
        if (prog_mode) return 32'h0;
        if (m_pc[31:16] != 16'h0) return 32'h0;
        return m_mem[m_pc[7:2]];
    endfunction

    function automatic logic [31:0] model_next_pc();
        logic [31:0] seq;
        seq = m_pc + 32'd4;
        if (Jr) return Read_data_1 & 32'hFFFF_FFFC;
        if (Jmp || Jal) return (seq & 32'hF000_0000) | ((model_instr() & 32'h03FF_FFFF) << 2);
        if ((Branch && Zero) || (nBranch && !Zero)) return Addr_result & 32'hFFFF_FFFC;
        return seq;
    endfunction

    // Architectural model of pc, count and the program image.
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_pc  <= 32'h0;
            m_cnt <= 32'h0;
            if (!m_seeded) begin
                for (int i = 0; i < 64; i++) m_val[i] <= 1'b0;
                m_seeded <= 1'b1;
            end
        end else if (prog_mode) begin
            m_pc  <= 32'h0;
            m_cnt <= 32'h0;
            if (prog_we && prog_addr < 14'd64) begin
                m_mem[prog_addr[5:0]] <= prog_data;
                m_val[prog_addr[5:0]] <= 1'b1;
            end
        end else if (!stall) begin
            m_pc  <= model_next_pc();
            m_cnt <= m_cnt + 32'd1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model.
    always @(negedge clock) begin
        if (cmp_en) begin
            check("pc", pc, m_pc);
            check("instr_count", instr_count, m_cnt);
            check("link_addr", link_addr, m_pc + 32'd4);
            check("branch_base_addr", branch_base_addr, m_pc + 32'd4);
            if (model_instr_known()) check("Instruction", Instruction, model_instr());
        end
    end

    task automatic tick();
        @(negedge clock);
        #2;
    endtask

    task automatic clr();
        Branch = 1'b0; nBranch = 1'b0; Jmp = 1'b0; Jal = 1'b0; Jr = 1'b0;
        Zero = 1'b0; Addr_result = 32'h0; Read_data_1 = 32'h0;
    endtask

    task automatic jr_to(input logic [31:0] tgt);
        Jr = 1'b1;
        Read_data_1 = tgt;
        tick();
        Jr = 1'b0;
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; prog_mode = 1'b1; prog_we = 1'b0;
        prog_addr = 14'h0; prog_data = 32'h0;
        clr();
        #1 reset = 1'b0;
        #1 cmp_en = 1'b1;
        check("rst_pc", pc, 32'h0);
        check("rst_count", instr_count, 32'h0);
        repeat (2) tick();
        reset = 1'b1;

        for (int i = 0; i < 32; i++) begin
            prog_we = 1'b1;
            prog_addr = 14'(i);
            prog_data = prog_word(i);
            tick();
        end
        prog_we = 1'b0;
        check("prog_nop", Instruction, 32'h0);

        prog_mode = 1'b0;
        #1;
        check("first_instr", Instruction, 32'h2008_0005);
        check("first_pc", pc, 32'h0);
        check("first_link", link_addr, 32'h4);
        tick(); check("seq_pc4", pc, 32'h4);
        tick(); check("seq_pc8", pc, 32'h8);

        Branch = 1'b1; Zero = 1'b1; Addr_result = 32'h14;
        tick(); check("beq_taken", pc, 32'h14); clr();
        jr_to(32'h8);
        Branch = 1'b1; Zero = 1'b0; Addr_result = 32'h14;
        tick(); check("beq_not_taken", pc, 32'hC); clr();
        jr_to(32'h8);
        nBranch = 1'b1; Zero = 1'b0; Addr_result = 32'h14;
        tick(); check("bne_taken", pc, 32'h14); clr();
        jr_to(32'h8);
        nBranch = 1'b1; Zero = 1'b1; Addr_result = 32'h14;
        tick(); check("bne_not_taken", pc, 32'hC); clr();

        jr_to(32'h20);
        Jal = 1'b1;
        #1;
        check("jal_link", link_addr, 32'h24);
        check("jal_instr", Instruction, 32'h0C00_0010);
        tick(); check("jal_target", pc, 32'h40); clr();
        Jr = 1'b1; Read_data_1 = 32'h27;
        tick(); check("jr_target", pc, 32'h24); clr();

        Jr = 1'b1; Jmp = 1'b1; Branch = 1'b1; Zero = 1'b1;
        Read_data_1 = 32'h10; Addr_result = 32'h50;
        tick(); check("prio_jr", pc, 32'h10); clr();

        stall = 1'b1; Branch = 1'b1; Zero = 1'b1; Addr_result = 32'h50;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("stall_pc", pc, 32'h10);
            check("stall_instr", Instruction, 32'h2400_0004);
            check("stall_count", instr_count, 32'd13);
        end
        stall = 1'b0; clr();
        tick();
        check("unstall_pc", pc, 32'h14);
        check("unstall_count", instr_count, 32'd14);

        jr_to(32'h0001_0000);
        check("oor_nop", Instruction, 32'h0);
        jr_to(32'hFFFF_FFFF);
        check("wrap_pc", pc, 32'hFFFF_FFFC);
        check("wrap_link", link_addr, 32'h0);
        tick(); check("wrap_next", pc, 32'h0);

        prog_we = 1'b1; prog_addr = 14'h0; prog_data = 32'hDEAD_BEEF;
        tick();
        jr_to(32'h30);
        prog_we = 1'b0;
        check("pre_reset_pc", pc, 32'h30);

        reset = 1'b0;
        #1;
        check("async_pc", pc, 32'h0);
        check("async_count", instr_count, 32'h0);
        check("retained_instr", Instruction, 32'h2008_0005);

        prog_mode = 1'b1; prog_we = 1'b1; prog_addr = 14'h1; prog_data = 32'hFFFF_FFFF;
        tick(); tick();
        prog_we = 1'b0; reset = 1'b1;
        tick();
        prog_mode = 1'b0;
        tick();
        check("dropped_write_pc", pc, 32'h4);
        check("dropped_write_instr", Instruction, 32'h2009_0003);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
